gray_sequence_decoder: RTL and testbench
========================================

Name: gray_sequence_decoder

Overview:
- Receiving end of the Gray-code counter interface: samples a WIDTH-bit Gray-coded position word and converts it back to binary.
- Classifies each new sample as hold, up-step or down-step, and keeps a signed position accumulator.
- Flags illegal multi-bit jumps and drops into a fault state until the input resynchronises.
- Sits downstream of the Gray counter / Gray-coded sensor bus.

Parameters:
- WIDTH, 3, Gray/binary word width
- POS_WIDTH, 8, width of signed position accumulator
- ERR_CNT_WIDTH, 4, width of saturating error counter

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- valid_in  input  1  gray_in is sampled this cycle
- gray_in  input  WIDTH  Gray-coded input word
- bin_out  output  WIDTH  registered binary value of last accepted sample
- step_up  output  1  one-cycle pulse on a +1 step
- step_down  output  1  one-cycle pulse on a -1 step
- wrap  output  1  one-cycle pulse on an up-step from 2^WIDTH-1 to 0 (also set with step_up)
- err_pulse  output  1  one-cycle pulse on an illegal jump
- fault  output  1  level; high while in FAULT state
- locked  output  1  level; high while in TRACK state
- position  output  POS_WIDTH  signed two's-complement step accumulator
- err_count  output  ERR_CNT_WIDTH  count of illegal jumps, saturating

Behaviour:
- Reset (async, active-high): state=IDLE. bin_out, position, err_count, prev_bin and all pulse and level outputs are 0. Reset asserted mid-operation discards everything immediately.
- Conversion (combinational): cur[WIDTH-1]=g[WIDTH-1]; cur[i]=cur[i+1]^g[i].
- delta = (cur - prev_bin) mod 2^WIDTH, computed in WIDTH bits.
- Latency: every output reflects the sample accepted at the previous rising edge (1 cycle). All outputs are registered.
- Pulses (step_up, step_down, wrap, err_pulse) are high for exactly one cycle and are 0 in any cycle after a clock with valid_in=0.
- valid_in=0: state, prev_bin, bin_out, position and err_count hold.
- IDLE, valid_in=1:
  - prev_bin=cur, bin_out=cur.
  - Go to TRACK.
  - No pulses; position unchanged.
- TRACK, valid_in=1:
  - delta=0: hold, no pulse.
  - delta=1: step_up, position+1. If prev_bin=2^WIDTH-1 and cur=0, also assert wrap.
  - delta=2^WIDTH-1: step_down, position-1. No wrap pulse on a down-wrap.
  - Any other delta: err_pulse, err_count+1 (saturate at all-ones), go to FAULT. Position is unchanged.
  - In every case prev_bin=cur and bin_out=cur.
- FAULT, valid_in=1:
  - delta in {0, 1, 2^WIDTH-1}: return to TRACK. The step is counted normally (pulses and position as in TRACK, including wrap).
  - Any other delta: stay in FAULT, err_pulse, err_count+1 (saturating).
  - prev_bin=cur and bin_out=cur always.
- locked=1 only in TRACK; fault=1 only in FAULT. Both are 0 in IDLE.
- position wraps two's-complement: +127 then +1 gives -128 with the defaults. No overflow flag.
- WIDTH=1 special case: delta=1 equals 2^WIDTH-1. Classify as step_up; down-steps cannot occur.

Test Plan:
- Reset, then valid_in=1 with gray_in sequence 000,001,011,010,110,111,101,100,000 -> bin_out follows 0..7,0 one cycle late; 8 step_up pulses; wrap pulse on the last step only; position=8; locked=1.
- From bin 3 (gray 010), apply 011,001,000,100 -> bin_out 2,1,0,7; 4 step_down pulses; no wrap; position decreases by 4.
- In TRACK at gray 000, apply 011 (bin 2) -> err_pulse=1, err_count=1, fault=1, position unchanged. Then 010 (bin 3) -> fault=0, locked=1, step_up, position+1.
- Alternate gray 000 and 110 for 20 valid cycles -> err_count saturates at 15; fault stays high; position never changes.
- Drop valid_in low for 5 cycles, holding gray_in random -> all outputs hold and pulses stay 0. Repeat the same gray value with valid_in=1 -> no pulse.
- Assert reset asynchronously between clock edges mid-sequence -> all outputs 0 immediately. The next valid sample only loads bin_out (IDLE to TRACK) with no step pulse.

Source files
------------

// File: rtl/gray_sequence_decoder.sv
// Gray-coded position receiver: converts samples to binary, classifies
// each step and tracks a signed position with illegal-jump fault handling.
module gray_sequence_decoder #(
    parameter int WIDTH         = 3,
    parameter int POS_WIDTH     = 8,
    parameter int ERR_CNT_WIDTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        valid_in,
    input  logic [WIDTH-1:0]            gray_in,
    output logic [WIDTH-1:0]            bin_out,
    output logic                        step_up,
    output logic                        step_down,
    output logic                        wrap,
    output logic                        err_pulse,
    output logic                        fault,
    output logic                        locked,
    output logic signed [POS_WIDTH-1:0] position,
    output logic [ERR_CNT_WIDTH-1:0]    err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_FAULT
    } state_t;

    localparam logic [WIDTH-1:0]         MAX_BIN = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    state_t                        state_q, state_d;
    logic [WIDTH-1:0]              bin_q, bin_d;
    logic signed [POS_WIDTH-1:0]   pos_q, pos_d;
    logic [ERR_CNT_WIDTH-1:0]      err_q, err_d;
    logic                          up_q, up_d;
    logic                          dn_q, dn_d;
    logic                          wrap_q, wrap_d;
    logic                          errp_q, errp_d;
    logic                          locked_q, locked_d;
    logic                          fault_q, fault_d;

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] delta;
    logic             is_hold;
    logic             is_up;
    logic             is_down;

    // Prefix XOR from the MSB down turns Gray into binary.
    always_comb begin
        cur = gray_in;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            cur = cur ^ (cur >> s);
        end
    end

    // With WIDTH=1 a delta of 1 is also all-ones; up takes priority.
    always_comb begin
        delta   = cur - bin_q;
        is_hold = (delta == '0);
        is_up   = (delta == WIDTH'(1));
        is_down = (delta == MAX_BIN) && !is_up;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        pos_d   = pos_q;
        err_d   = err_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        wrap_d  = 1'b0;
        errp_d  = 1'b0;
        if (valid_in) begin
            bin_d = cur;
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_TRACK;
                end
                S_TRACK, S_FAULT: begin
                    if (is_hold || is_up || is_down) begin
                        state_d = S_TRACK;
                        if (is_up) begin
                            up_d   = 1'b1;
                            pos_d  = pos_q + POS_WIDTH'(1);
                            wrap_d = (bin_q == MAX_BIN) && (cur == '0);
                        end else if (is_down) begin
                            dn_d  = 1'b1;
                            pos_d = pos_q - POS_WIDTH'(1);
                        end
                    end else begin
                        state_d = S_FAULT;
                        errp_d  = 1'b1;
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        locked_d = (state_d == S_TRACK);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            pos_q    <= '0;
            err_q    <= '0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            wrap_q   <= 1'b0;
            errp_q   <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            pos_q    <= pos_d;
            err_q    <= err_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            wrap_q   <= wrap_d;
            errp_q   <= errp_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
        end
    end

    assign bin_out   = bin_q;
    assign step_up   = up_q;
    assign step_down = dn_q;
    assign wrap      = wrap_q;
    assign err_pulse = errp_q;
    assign fault     = fault_q;
    assign locked    = locked_q;
    assign position  = pos_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gray_sequence_decoder.sv
// Directed bench for gray_sequence_decoder: counting, faults,
// saturation, valid gaps, async reset and position wrap.
module tb_gray_sequence_decoder;

    logic              clock = 1'b0;
    logic              reset;
    logic              valid_in;
    logic [2:0]        gray_in;
    logic [2:0]        bin_out;
    logic              step_up;
    logic              step_down;
    logic              wrap;
    logic              err_pulse;
    logic              fault;
    logic              locked;
    logic signed [7:0] position;
    logic [3:0]        err_count;

    int vectors     = 0;
    int miscompares = 0;

    gray_sequence_decoder #(
        .WIDTH(3),
        .POS_WIDTH(8),
        .ERR_CNT_WIDTH(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .valid_in (valid_in),
        .gray_in  (gray_in),
        .bin_out  (bin_out),
        .step_up  (step_up),
        .step_down(step_down),
        .wrap     (wrap),
        .err_pulse(err_pulse),
        .fault    (fault),
        .locked   (locked),
        .position (position),
        .err_count(err_count)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] g_of(int b);
        logic [2:0] v;
        v = 3'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic step(input logic v, input logic [2:0] g);
        valid_in = v;
        gray_in  = g;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        gray_in  = 3'b000;
        #2;
        vectors++;
        if ({bin_out, step_up, step_down, wrap, err_pulse, fault, locked} !== 9'd0
            || position !== 8'sd0 || err_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: bin=%0d flags=%b%b%b%b%b%b pos=%0d err=%0d, want all 0",
                     bin_out, step_up, step_down, wrap, err_pulse, fault, locked,
                     position, err_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1'b0, 3'b000);
        vectors++;
        if (locked !== 1'b0 || fault !== 1'b0 || bin_out !== 3'd0) begin
            miscompares++;
            $display("FAIL idle_hold: locked=%b fault=%b bin=%0d, want 0 0 0",
                     locked, fault, bin_out);
        end
    endtask

    task automatic test_count_up();
        logic [2:0] seq [9];
        int ups;
        seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                3'b111, 3'b101, 3'b100, 3'b000};
        ups = 0;
        for (int k = 0; k < 9; k++) begin
            step(1'b1, seq[k]);
            ups += int'(step_up);
            vectors++;
            if (bin_out !== 3'(k % 8) || step_up !== (k > 0)
                || wrap !== (k == 8) || step_down !== 1'b0
                || position !== 8'(k) || locked !== 1'b1) begin
                miscompares++;
                $display("FAIL count_up[%0d]: bin=%0d up=%b wrap=%b dn=%b pos=%0d lk=%b, want bin=%0d up=%b wrap=%b dn=0 pos=%0d lk=1",
                         k, bin_out, step_up, wrap, step_down, position, locked,
                         k % 8, k > 0, k == 8, k);
            end
        end
        vectors++;
        if (ups != 8) begin
            miscompares++;
            $display("FAIL up_pulse_total: got %0d, want 8", ups);
        end
    endtask

    task automatic test_count_down();
        logic [2:0] seq [4];
        logic [2:0] expb [4];
        seq  = '{3'b011, 3'b001, 3'b000, 3'b100};
        expb = '{3'd2, 3'd1, 3'd0, 3'd7};
        step(1'b1, 3'b001);
        step(1'b1, 3'b011);
        step(1'b1, 3'b010);
        vectors++;
        if (bin_out !== 3'd3 || position !== 8'sd11) begin
            miscompares++;
            $display("FAIL climb_to_3: bin=%0d pos=%0d, want 3 11", bin_out, position);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, seq[k]);
            vectors++;
            if (bin_out !== expb[k] || step_down !== 1'b1 || step_up !== 1'b0
                || wrap !== 1'b0 || position !== 8'(10 - k)) begin
                miscompares++;
                $display("FAIL count_down[%0d]: bin=%0d dn=%b up=%b wrap=%b pos=%0d, want bin=%0d dn=1 up=0 wrap=0 pos=%0d",
                         k, bin_out, step_down, step_up, wrap, position, expb[k], 10 - k);
            end
        end
    endtask

    task automatic test_fault_recover();
        step(1'b1, 3'b000);
        vectors++;
        if (bin_out !== 3'd0 || wrap !== 1'b1 || position !== 8'sd8) begin
            miscompares++;
            $display("FAIL wrap_7_to_0: bin=%0d wrap=%b pos=%0d, want 0 1 8",
                     bin_out, wrap, position);
        end
        step(1'b1, 3'b011);
        vectors++;
        if (err_pulse !== 1'b1 || err_count !== 4'd1 || fault !== 1'b1
            || locked !== 1'b0 || position !== 8'sd8 || bin_out !== 3'd2) begin
            miscompares++;
            $display("FAIL jump_err: ep=%b ec=%0d f=%b lk=%b pos=%0d bin=%0d, want 1 1 1 0 8 2",
                     err_pulse, err_count, fault, locked, position, bin_out);
        end
        step(1'b1, 3'b010);
        vectors++;
        if (fault !== 1'b0 || locked !== 1'b1 || step_up !== 1'b1
            || err_pulse !== 1'b0 || position !== 8'sd9 || bin_out !== 3'd3) begin
            miscompares++;
            $display("FAIL recover: f=%b lk=%b up=%b ep=%b pos=%0d bin=%0d, want 0 1 1 0 9 3",
                     fault, locked, step_up, err_pulse, position, bin_out);
        end
    endtask

    task automatic test_err_saturate();
        int want;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, (k % 2 == 0) ? 3'b000 : 3'b110);
            want = (k + 2 > 15) ? 15 : k + 2;
            vectors++;
            if (err_pulse !== 1'b1 || fault !== 1'b1 || err_count !== 4'(want)
                || position !== 8'sd9 || step_up !== 1'b0 || step_down !== 1'b0) begin
                miscompares++;
                $display("FAIL err_sat[%0d]: ep=%b f=%b ec=%0d pos=%0d up=%b dn=%b, want 1 1 %0d 9 0 0",
                         k, err_pulse, fault, err_count, position, step_up, step_down, want);
            end
        end
    endtask

    task automatic test_valid_gap();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 3'($urandom_range(0, 7)));
            vectors++;
            if (step_up !== 1'b0 || step_down !== 1'b0 || wrap !== 1'b0
                || err_pulse !== 1'b0 || bin_out !== 3'd4 || fault !== 1'b1
                || err_count !== 4'd15 || position !== 8'sd9) begin
                miscompares++;
                $display("FAIL valid_gap[%0d]: up=%b dn=%b wr=%b ep=%b bin=%0d f=%b ec=%0d pos=%0d, want 0 0 0 0 4 1 15 9",
                         k, step_up, step_down, wrap, err_pulse, bin_out, fault,
                         err_count, position);
            end
        end
        step(1'b1, 3'b110);
        vectors++;
        if (step_up !== 1'b0 || step_down !== 1'b0 || err_pulse !== 1'b0
            || locked !== 1'b1 || fault !== 1'b0 || position !== 8'sd9) begin
            miscompares++;
            $display("FAIL repeat_hold: up=%b dn=%b ep=%b lk=%b f=%b pos=%0d, want 0 0 0 1 0 9",
                     step_up, step_down, err_pulse, locked, fault, position);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 3'b111);
        vectors++;
        if (step_up !== 1'b1 || position !== 8'sd10) begin
            miscompares++;
            $display("FAIL pre_reset_step: up=%b pos=%0d, want 1 10", step_up, position);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({bin_out, step_up, step_down, wrap, err_pulse, fault, locked} !== 9'd0
            || position !== 8'sd0 || err_count !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: bin=%0d flags=%b%b%b%b%b%b pos=%0d ec=%0d, want all 0",
                     bin_out, step_up, step_down, wrap, err_pulse, fault, locked,
                     position, err_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1'b1, 3'b101);
        vectors++;
        if (bin_out !== 3'd6 || step_up !== 1'b0 || step_down !== 1'b0
            || err_pulse !== 1'b0 || locked !== 1'b1 || position !== 8'sd0) begin
            miscompares++;
            $display("FAIL reload: bin=%0d up=%b dn=%b ep=%b lk=%b pos=%0d, want 6 0 0 0 1 0",
                     bin_out, step_up, step_down, err_pulse, locked, position);
        end
        step(1'b1, 3'b100);
        step(1'b1, 3'b000);
        vectors++;
        if (wrap !== 1'b1 || step_up !== 1'b1 || position !== 8'sd2) begin
            miscompares++;
            $display("FAIL post_reset_wrap: wrap=%b up=%b pos=%0d, want 1 1 2",
                     wrap, step_up, position);
        end
    endtask

    task automatic test_pos_wrap();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step(1'b1, 3'b000);
        for (int k = 1; k <= 128; k++) begin
            step(1'b1, g_of(k));
            if (k == 127) begin
                vectors++;
                if (position !== 8'sd127) begin
                    miscompares++;
                    $display("FAIL pos_127: got %0d, want 127", position);
                end
            end
        end
        vectors++;
        if (position !== -8'sd128 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL pos_wrap: pos=%0d lk=%b, want -128 1", position, locked);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_fault_recover();
        test_err_saturate();
        test_valid_gap();
        test_async_reset();
        test_pos_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
